// File: rtl/shift_load_sequencer.sv
// Parallel-in/serial-out sequencer that drives the shifter's 2-bit mode code and keeps a shadow copy.
// Define SHIFT_PARITY_EN to append an even-parity bit after the data bits of every frame.
`timescale 1ns/1ps
module shift_load_sequencer #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic [BUS_WIDTH-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic                 dir_i,
   input  logic                 fill_i,
   input  logic                 hold_i,
   output logic [1:0]           mode_o,
   output logic [BUS_WIDTH-1:0] data_o,
   output logic                 serial_o,
   output logic                 serial_valid_o,
   output logic                 last_o,
   output logic                 busy_o
);
   localparam int CW = $clog2(BUS_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(BUS_WIDTH - 1);

`ifdef SHIFT_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

   state_t               state;
   logic [BUS_WIDTH-1:0] shadow;
   logic [CW-1:0]        count;
   logic                 dir;
   logic                 advance;
   logic                 last;
   logic                 accept;

   assign advance = (state == SHIFT) & !hold_i;

`ifdef SHIFT_PARITY_EN
   logic parity;
   assign last = (state == PARITY) & !hold_i;
`else
   assign last = advance & (count == LAST_COUNT);
`endif

   // Outputs are forced low while reset is held, even though state already reads IDLE.
   assign ready_o        = !rst_i & ((state == IDLE) | last);
   assign accept         = valid_i & ready_o;
   assign busy_o         = !rst_i & (state != IDLE);
   assign last_o         = !rst_i & last;
   assign serial_valid_o = !rst_i & (state != IDLE) & !hold_i;
   assign data_o         = shadow;

   always_comb begin
      serial_o = 1'b0;
      if (!rst_i && state == SHIFT)
         serial_o = dir ? shadow[0] : shadow[BUS_WIDTH-1];
`ifdef SHIFT_PARITY_EN
      else if (!rst_i && state == PARITY)
         serial_o = parity;
`endif
   end

   // A load on the final bit overrides the shift so frames stream without a bubble.
   always_comb begin
      mode_o = 2'b00;
      if (accept)
         mode_o = 2'b01;
      else if (advance)
         mode_o = {1'b1, dir};
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         shadow <= '0;
         count  <= '0;
         dir    <= 1'b0;
`ifdef SHIFT_PARITY_EN
         parity <= 1'b0;
`endif
      end else if (accept) begin
         state  <= SHIFT;
         shadow <= data_i;
         count  <= '0;
         dir    <= dir_i;
`ifdef SHIFT_PARITY_EN
         parity <= ^data_i;
`endif
      end else if (advance) begin
         shadow <= dir ? {fill_i, shadow[BUS_WIDTH-1:1]} : {shadow[BUS_WIDTH-2:0], fill_i};
         count  <= count + 1'b1;
         if (count == LAST_COUNT) begin
`ifdef SHIFT_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
         end
      end
`ifdef SHIFT_PARITY_EN
      else if (last) begin
         state <= IDLE;
      end
`endif
   end
endmodule

// File: tb/tb_shift_load_sequencer.sv
// Self-checking bench for shift_load_sequencer: frame table, corner sequences and a randomized model run.
`timescale 1ns/1ps
module tb_shift_load_sequencer;
   localparam int W = 8;
`ifdef SHIFT_PARITY_EN
   localparam int PX = 1;
`else
   localparam int PX = 0;
`endif
   localparam int FL = W + PX;

   logic         clk = 1'b0;
   logic         rst_i, valid_i, dir_i, fill_i, hold_i;
   logic [W-1:0] data_i;
   logic         ready_o, serial_o, serial_valid_o, last_o, busy_o;
   logic [1:0]   mode_o;
   logic [W-1:0] data_o;

   int checks = 0;
   int errors = 0;

   shift_load_sequencer #(.BUS_WIDTH(W)) dut (
      .clk(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .dir_i(dir_i), .fill_i(fill_i), .hold_i(hold_i), .mode_o(mode_o), .data_o(data_o),
      .serial_o(serial_o), .serial_valid_o(serial_valid_o), .last_o(last_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  word;
      logic        dir;
      logic        fill;
      logic [31:0] hold_mask;
      logic [7:0]  exp_bits;
      logic        exp_par;
      logic [7:0]  exp_final;
      int          exp_last;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_frame(input vec_t v);
      logic [7:0] got;
      logic       par_got;
      int         nbits, last_at;
      got = '0; par_got = 1'b0; nbits = 0; last_at = 0;
      @(negedge clk);
      data_i = v.word; dir_i = v.dir; fill_i = v.fill; valid_i = 1'b1; hold_i = 1'b0;
      #1;
      check("accept_ready", ready_o, 1);
      check("load_mode", mode_o, 2'b01);
      for (int c = 1; c <= 24 && last_at == 0; c++) begin
         @(negedge clk);
         valid_i = 1'b0;
         hold_i  = v.hold_mask[c-1];
         #1;
         if (serial_valid_o) begin
            if (nbits < W) begin
               got = {got[6:0], serial_o};
               check("shift_mode", mode_o, {1'b1, v.dir});
            end else begin
               par_got = serial_o;
            end
            nbits++;
         end
         if (last_o) last_at = c;
      end
      check("frame_bits", got, v.exp_bits);
      check("frame_bit_count", nbits, FL);
      check("frame_last_cycle", last_at, v.exp_last + PX);
`ifdef SHIFT_PARITY_EN
      check("frame_parity", par_got, v.exp_par);
`endif
      @(negedge clk);
      hold_i = 1'b0;
      #1;
      check("frame_final_data", data_o, v.exp_final);
      check("frame_idle_busy", busy_o, 0);
      check("frame_idle_ready", ready_o, 1);
      $display("frame word=%h dir=%0d fill=%0d bits=%h last_at=%0d data_o=%h",
               v.word, v.dir, v.fill, got, last_at, data_o);
   endtask

   // Reference model: queue of bits still to be emitted in the current frame.
   logic       q[$];
   int         data_left;
   logic [7:0] md;
   logic       mdir;

   initial begin
      logic [2*FL-1:0] stream, exp_stream;
      int gaps, seen_last;
      logic e_busy, e_last, e_ready, e_acc;
      logic [1:0] e_mode;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 32'h0,  8'hA5, 1'b0, 8'h00, 8};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 32'h0,  8'hA5, 1'b0, 8'h00, 8};
      vecs[2] = '{8'h81, 1'b0, 1'b1, 32'hC,  8'h81, 1'b0, 8'hFF, 10};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 32'h80, 8'h3C, 1'b0, 8'hFF, 9};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 32'h0,  8'h80, 1'b1, 8'h00, 8};
      vecs[5] = '{8'h07, 1'b0, 1'b0, 32'h1,  8'h07, 1'b1, 8'h00, 9};
      vecs[6] = '{8'h03, 1'b1, 1'b1, 32'h0,  8'hC0, 1'b0, 8'hFF, 8};

      // Reset state, with valid_i high to show it is masked
      rst_i = 1'b1; valid_i = 1'b1; data_i = 8'h5A; dir_i = 1'b0; fill_i = 1'b0; hold_i = 1'b0;
      #1;
      check("rst_ready", ready_o, 0);
      check("rst_mode", mode_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_valid", serial_valid_o, 0);
      check("rst_last", last_o, 0);
      check("rst_data", data_o, 0);
      @(negedge clk);
      rst_i = 1'b0; valid_i = 1'b0;
      #1;
      check("idle_ready", ready_o, 1);
      check("idle_mode", mode_o, 2'b00);
      valid_i = 1'b1;
      #1;
      check("idle_valid_mode", mode_o, 2'b01);
      valid_i = 1'b0;

      foreach (vecs[i]) run_frame(vecs[i]);

      // Back-to-back streaming with valid_i held high
      @(negedge clk);
      data_i = 8'h0F; dir_i = 1'b0; fill_i = 1'b0; valid_i = 1'b1; hold_i = 1'b0;
      gaps = 0; stream = '0;
      for (int c = 1; c <= 2 * FL; c++) begin
         @(negedge clk);
         if (c == 1) data_i = 8'hF0;
         if (c == FL + 1) valid_i = 1'b0;
         #1;
         if (!serial_valid_o) gaps++;
         stream = {stream[2*FL-2:0], serial_o};
         if (c == FL) begin
            check("stream_reload_mode", mode_o, 2'b01);
            check("stream_first_last", last_o, 1);
         end
      end
`ifdef SHIFT_PARITY_EN
      exp_stream = {8'h0F, 1'b0, 8'hF0, 1'b0};
`else
      exp_stream = {8'h0F, 8'hF0};
`endif
      check("stream_bits", stream, exp_stream);
      check("stream_gaps", gaps, 0);
      @(negedge clk);
      #1;
      check("stream_end_busy", busy_o, 0);
      $display("stream bits=%h gaps=%0d", stream, gaps);

      // Asynchronous reset mid-frame
      @(negedge clk);
      data_i = 8'hFF; dir_i = 1'b0; fill_i = 1'b1; valid_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         valid_i = 1'b0;
      end
      @(negedge clk);
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_valid", serial_valid_o, 0);
      check("arst_serial", serial_o, 0);
      check("arst_ready", ready_o, 0);
      check("arst_mode", mode_o, 0);
      check("arst_last", last_o, 0);
      check("arst_data", data_o, 0);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("arst_release_ready", ready_o, 1);
      seen_last = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (last_o || busy_o) seen_last++;
      end
      check("arst_no_last", seen_last, 0);
      $display("async reset mid-frame: ready=%0d after release", ready_o);

      // Randomized run against the queue model
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      rst_i = 1'b0;
      q.delete(); data_left = 0; md = '0; mdir = 1'b0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         valid_i = 1'($urandom_range(0, 1));
         data_i  = 8'($urandom);
         dir_i   = 1'($urandom_range(0, 1));
         fill_i  = 1'($urandom_range(0, 1));
         hold_i  = ($urandom_range(0, 3) == 0);
         #1;
         e_busy  = (q.size() != 0);
         e_last  = (q.size() == 1) && !hold_i;
         e_ready = !e_busy || e_last;
         e_acc   = valid_i && e_ready;
         e_mode  = e_acc ? 2'b01 : ((e_busy && !hold_i && data_left > 0) ? {1'b1, mdir} : 2'b00);
         check("rnd_ready", ready_o, e_ready);
         check("rnd_busy", busy_o, e_busy);
         check("rnd_last", last_o, e_last);
         check("rnd_valid", serial_valid_o, e_busy && !hold_i);
         check("rnd_mode", mode_o, e_mode);
         check("rnd_data", data_o, md);
         if (e_busy) check("rnd_serial", serial_o, q[0]);
         @(posedge clk);
         if (e_acc) begin
            md = data_i; mdir = dir_i;
            q.delete();
            for (int b = 0; b < W; b++) q.push_back(dir_i ? data_i[b] : data_i[W-1-b]);
`ifdef SHIFT_PARITY_EN
            q.push_back(^data_i);
`endif
            data_left = W;
            $display("rnd accept word=%h dir=%0d at %0t", data_i, dir_i, $time);
         end else if (e_busy && !hold_i) begin
            void'(q.pop_front());
            if (data_left > 0) begin
               md = mdir ? {fill_i, md[7:1]} : {md[6:0], fill_i};
               data_left--;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
